// File: rtl/rank_filter.sv
// Streaming rank selector: collects one frame of N_PIXELS samples and returns
// the sample of the requested rank using bubble passes in the shorter direction.
module rank_filter #(
  parameter int WIDTH    = 8,
  parameter int N_PIXELS = 9,
  parameter int RW       = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DSI,
  input  logic [WIDTH-1:0] DI,
  input  logic [RW-1:0]    RANK,
  output logic [WIDTH-1:0] DO,
  output logic             DSO,
  output logic             BUSY,
  output logic             ERR
);

  localparam int CW   = $clog2(N_PIXELS + 1);
  localparam int JMAX = (N_PIXELS > 1) ? N_PIXELS - 2 : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SORT
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [WIDTH-1:0] r_buf [N_PIXELS];
  logic [CW-1:0]    r_cnt;
  logic [RW-1:0]    r_rank;
  logic             r_up;
  logic [CW-1:0]    r_np;
  logic [CW-1:0]    r_pass;
  logic [RW-1:0]    r_j;
  logic [WIDTH-1:0] r_do;
  logic             r_dso;

  logic [RW-1:0]    w_rank_sat;
  logic [CW-1:0]    w_nr;
  logic [CW-1:0]    w_r1;
  logic             w_up;
  logic [CW-1:0]    w_np;
  logic [RW-1:0]    w_jh;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_swap;
  logic [RW-1:0]    w_last;
  logic             w_pass_end;
  logic             w_done;
  logic             w_err;

  // Rank saturation and choice of the cheaper extraction direction
  always_comb begin
    w_rank_sat = RANK;
    if (int'(RANK) >= N_PIXELS)
      w_rank_sat = RW'(N_PIXELS - 1);
    w_nr = CW'(N_PIXELS) - CW'(w_rank_sat);
    w_r1 = CW'(w_rank_sat) + CW'(1);
    w_up = (w_nr <= w_r1);
    w_np = w_up ? w_nr : w_r1;
  end

  always_comb begin
    w_jh       = r_j + RW'(1);
    w_a        = r_buf[r_j];
    w_b        = r_buf[w_jh];
    w_swap     = (w_a > w_b);
    w_last     = r_up ? (RW'(JMAX) - RW'(r_pass)) : RW'(r_pass);
    w_pass_end = (r_j == w_last);
    w_done     = (r_pass == r_np);
  end

  always_comb begin
    w_state_nx = r_state;
    w_err      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (DSI)
          w_state_nx = (N_PIXELS == 1) ? S_SORT : S_LOAD;
      end
      S_LOAD: begin
        if (DSI) begin
          if (r_cnt == CW'(N_PIXELS - 1))
            w_state_nx = S_SORT;
        end else begin
          w_err      = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      S_SORT: begin
        w_err = DSI;
        if (w_done)
          w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nx;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N_PIXELS; i++)
        r_buf[i] <= '0;
      r_cnt  <= '0;
      r_rank <= '0;
      r_up   <= 1'b0;
      r_np   <= '0;
      r_pass <= '0;
      r_j    <= '0;
      r_do   <= '0;
      r_dso  <= 1'b0;
    end else begin
      r_dso <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (DSI) begin
            r_buf[0] <= DI;
            r_rank   <= w_rank_sat;
            r_up     <= w_up;
            r_np     <= w_np;
            r_cnt    <= CW'(1);
            // A single-sample frame needs no compare passes
            r_pass   <= (N_PIXELS == 1) ? w_np : '0;
            r_j      <= w_up ? '0 : RW'(JMAX);
          end
        end
        S_LOAD: begin
          if (DSI) begin
            r_buf[RW'(r_cnt)] <= DI;
            r_cnt             <= r_cnt + CW'(1);
          end
        end
        S_SORT: begin
          if (!w_done) begin
            if (w_swap) begin
              r_buf[r_j]  <= w_b;
              r_buf[w_jh] <= w_a;
            end
            if (w_pass_end) begin
              r_pass <= r_pass + CW'(1);
              r_j    <= r_up ? '0 : RW'(JMAX);
            end else begin
              r_j <= r_up ? w_jh : (r_j - RW'(1));
            end
          end else begin
            r_do  <= r_buf[r_rank];
            r_dso <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign DO   = r_do;
  assign DSO  = r_dso;
  assign BUSY = (r_state == S_SORT);
  assign ERR  = w_err;

endmodule
